// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller (master) and scan_sequencer (slave).
// The pass_cnt member exists only when SCAN_PASS_CNT_EN is defined.
interface scan_sequencer_if #(
  parameter int DWELL_W = 8,
  parameter int ADDR_W  = 4
);
  logic                 start;
  logic                 stop;
  logic                 mode_cont;
  logic [DWELL_W-1:0]   dwell;
  logic [2**ADDR_W-1:0] ch_mask;
  logic [ADDR_W-1:0]    addr;
  logic                 enable;
  logic                 busy;
  logic                 done;
`ifdef SCAN_PASS_CNT_EN
  logic [7:0]           pass_cnt;

  modport master (output start, stop, mode_cont, dwell, ch_mask,
                  input  addr, enable, busy, done, pass_cnt);
  modport slave  (input  start, stop, mode_cont, dwell, ch_mask,
                  output addr, enable, busy, done, pass_cnt);
`else
  modport master (output start, stop, mode_cont, dwell, ch_mask,
                  input  addr, enable, busy, done);
  modport slave  (input  start, stop, mode_cont, dwell, ch_mask,
                  output addr, enable, busy, done);
`endif
endinterface

// File: rtl/scan_sequencer.sv
// Masked channel scanner driving a 4-to-16 decoder with dwell and break-before-make gap.
// Optional pass counter output enabled by defining SCAN_PASS_CNT_EN.
module scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int ADDR_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  scan_sequencer_if.slave bus
);
  localparam int NCH = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic               mode_q, mode_d;
  logic [NCH-1:0]     higher_mask;
  logic               has_higher;
`ifdef SCAN_PASS_CNT_EN
  logic [7:0]         pass_cnt_q, pass_cnt_d;
`endif

  function automatic logic [ADDR_W-1:0] lowest_set(input logic [NCH-1:0] m);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (m[i]) idx = ADDR_W'(i);
    return idx;
  endfunction

  // Latched channels strictly above the current one; empty means the pass is complete.
  always_comb begin
    higher_mask = '0;
    for (int i = 0; i < NCH; i++)
      higher_mask[i] = mask_q[i] && (i > int'(addr_q));
  end

  assign has_higher = |higher_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      mask_q   <= '0;
      mode_q   <= 1'b0;
`ifdef SCAN_PASS_CNT_EN
      pass_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
`ifdef SCAN_PASS_CNT_EN
      pass_cnt_q <= pass_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.start && (bus.ch_mask != '0)) state_d = ACTIVE;
        ACTIVE:  if (cnt_q == '0) state_d = GAP;
        GAP:     state_d = (has_higher || mode_q) ? ACTIVE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs and datapath; stop overrides everything and never pulses done.
  always_comb begin
    addr_d   = addr_q;
    enable_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
`ifdef SCAN_PASS_CNT_EN
    pass_cnt_d = pass_cnt_q;
`endif
    if (bus.stop) begin
      busy_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.ch_mask != '0) begin
              mask_d   = bus.ch_mask;
              dwell_d  = bus.dwell;
              mode_d   = bus.mode_cont;
              addr_d   = lowest_set(bus.ch_mask);
              enable_d = 1'b1;
              busy_d   = 1'b1;
              cnt_d    = bus.dwell;
`ifdef SCAN_PASS_CNT_EN
              pass_cnt_d = '0;
`endif
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (cnt_q != '0) begin
            cnt_d    = cnt_q - 1'b1;
            enable_d = 1'b1;
          end
        end
        GAP: begin
          if (has_higher) begin
            addr_d   = lowest_set(higher_mask);
            enable_d = 1'b1;
            cnt_d    = dwell_q;
          end else begin
`ifdef SCAN_PASS_CNT_EN
            if (pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
`endif
            if (mode_q) begin
              addr_d   = lowest_set(mask_q);
              enable_d = 1'b1;
              cnt_d    = dwell_q;
            end else begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end
          end
        end
        default: busy_d = 1'b0;
      endcase
    end
  end

  assign bus.addr   = addr_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
`ifdef SCAN_PASS_CNT_EN
  assign bus.pass_cnt = pass_cnt_q;
`endif
endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized self-checking bench for scan_sequencer against a per-cycle waveform model.
// Pass counter checks are compiled in when SCAN_PASS_CNT_EN is defined.
module tb_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  scan_sequencer_if bus ();

  scan_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  int   pexp_q[$];
  logic [3:0] model_addr = 4'd0;

  function automatic obs_t sample_outputs();
    obs_t o;
    o.addr = bus.addr;
    o.en   = bus.enable;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  // Expected outputs for every cycle after the start edge: each channel in ascending
  // order is held dwell+1 cycles, followed by one gap cycle at the same address.
  task automatic build_model(input logic [15:0] mask, input int dw, input bit cont,
                             input int max_cycles);
    obs_t e;
    int   passes;
    bit   halt;
    passes = 0;
    halt   = 1'b0;
    exp_q.delete();
    pexp_q.delete();
    if (mask == 16'd0) begin
      e.addr = model_addr; e.en = 1'b0; e.busy = 1'b0; e.done = 1'b1;
      exp_q.push_back(e); pexp_q.push_back(-1);
      e.done = 1'b0;
      exp_q.push_back(e); pexp_q.push_back(-1);
      return;
    end
    while (!halt) begin
      for (int ch = 0; ch < 16 && !halt; ch++) begin
        if (mask[ch]) begin
          e.addr = ch[3:0]; e.en = 1'b1; e.busy = 1'b1; e.done = 1'b0;
          for (int k = 0; k <= dw; k++) begin
            exp_q.push_back(e); pexp_q.push_back(passes > 255 ? 255 : passes);
          end
          e.en = 1'b0;
          exp_q.push_back(e); pexp_q.push_back(passes > 255 ? 255 : passes);
          if (exp_q.size() >= max_cycles) halt = 1'b1;
        end
      end
      if (!halt) begin
        passes++;
        if (!cont) begin
          e.en = 1'b0; e.busy = 1'b0; e.done = 1'b1;
          exp_q.push_back(e); pexp_q.push_back(passes);
          e.done = 1'b0;
          exp_q.push_back(e); pexp_q.push_back(passes);
          halt = 1'b1;
        end
      end
    end
    model_addr = exp_q[$].addr;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    #1;
    got = sample_outputs();
    checks++;
    if (got !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h, expected 00", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = sample_outputs();
      checks++;
      if (got !== 7'd0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: got %h, expected 00", i, got);
      end
    end
    model_addr = 4'd0;
  endtask

  task automatic test_single_pass();
    obs_t got;
    build_model(16'h0005, 2, 1'b0, 1000);
    bus.ch_mask = 16'h0005; bus.dwell = 8'd2; bus.mode_cont = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      got = sample_outputs();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL single_pass cycle %0d: got addr=%0d en=%0b busy=%0b done=%0b, expected addr=%0d en=%0b busy=%0b done=%0b",
                 i + 1, got.addr, got.en, got.busy, got.done,
                 exp_q[i].addr, exp_q[i].en, exp_q[i].busy, exp_q[i].done);
      end
`ifdef SCAN_PASS_CNT_EN
      checks++;
      if (bus.pass_cnt !== pexp_q[i][7:0]) begin
        errors++;
        $display("[TB] FAIL single_pass_cnt cycle %0d: got %0d, expected %0d", i + 1, bus.pass_cnt, pexp_q[i]);
      end
`endif
    end
  endtask

  // Single-pass scans while ch_mask/dwell/mode_cont/start are scrambled mid-scan.
  task automatic test_random_scans();
    obs_t        got;
    logic [15:0] mask;
    int          dw;
    for (int n = 0; n < 10; n++) begin
      mask = (n == 0) ? 16'h8000 : (n == 1) ? 16'hFFFF : 16'($urandom_range(1, 16'hFFFF));
      if (n >= 2 && n % 2 == 0) mask = mask & 16'($urandom) | 16'h0001 << $urandom_range(0, 15);
      dw = $urandom_range(0, 3);
      build_model(mask, dw, 1'b0, 1000);
      bus.ch_mask = mask; bus.dwell = 8'(dw); bus.mode_cont = 1'b0; bus.start = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        got = sample_outputs();
        checks++;
        if (got !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL random_scan %0d mask=%h cycle %0d: got addr=%0d en=%0b busy=%0b done=%0b, expected addr=%0d en=%0b busy=%0b done=%0b",
                   n, mask, i + 1, got.addr, got.en, got.busy, got.done,
                   exp_q[i].addr, exp_q[i].en, exp_q[i].busy, exp_q[i].done);
        end
        bus.ch_mask   = 16'($urandom);
        bus.dwell     = 8'($urandom);
        bus.mode_cont = 1'($urandom);
        bus.start     = exp_q[i].busy ? 1'($urandom) : 1'b0;
      end
      bus.start = 1'b0;
    end
  endtask

  task automatic test_continuous();
    obs_t        got;
    logic [15:0] mask;
    int          dw;
    for (int n = 0; n < 3; n++) begin
      mask = (n == 0) ? 16'h8001 : (n == 1) ? (16'h0001 << $urandom_range(0, 15))
                                            : 16'($urandom_range(1, 16'hFFFF));
      dw = (n == 0) ? 0 : $urandom_range(0, 2);
      build_model(mask, dw, 1'b1, 40);
      bus.ch_mask = mask; bus.dwell = 8'(dw); bus.mode_cont = 1'b1; bus.start = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        got = sample_outputs();
        checks++;
        if (got !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL continuous %0d mask=%h cycle %0d: got addr=%0d en=%0b busy=%0b done=%0b, expected addr=%0d en=%0b busy=%0b done=%0b",
                   n, mask, i + 1, got.addr, got.en, got.busy, got.done,
                   exp_q[i].addr, exp_q[i].en, exp_q[i].busy, exp_q[i].done);
        end
`ifdef SCAN_PASS_CNT_EN
        checks++;
        if (bus.pass_cnt !== pexp_q[i][7:0]) begin
          errors++;
          $display("[TB] FAIL continuous_pass_cnt %0d cycle %0d: got %0d, expected %0d", n, i + 1, bus.pass_cnt, pexp_q[i]);
        end
`endif
        bus.ch_mask = 16'($urandom);
        bus.start   = 1'($urandom);
      end
      bus.start = 1'b0;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      got = sample_outputs();
      checks++;
      if (got.en !== 1'b0 || got.busy !== 1'b0 || got.done !== 1'b0 || got.addr !== model_addr) begin
        errors++;
        $display("[TB] FAIL continuous_stop %0d: got addr=%0d en=%0b busy=%0b done=%0b, expected addr=%0d en=0 busy=0 done=0",
                 n, got.addr, got.en, got.busy, got.done, model_addr);
      end
    end
  endtask

  task automatic test_empty_mask();
    obs_t got;
    build_model(16'h0000, 3, 1'b0, 1000);
    bus.ch_mask = 16'h0000; bus.dwell = 8'd3; bus.mode_cont = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      got = sample_outputs();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL empty_mask cycle %0d: got addr=%0d en=%0b busy=%0b done=%0b, expected addr=%0d en=%0b busy=%0b done=%0b",
                 i + 1, got.addr, got.en, got.busy, got.done,
                 exp_q[i].addr, exp_q[i].en, exp_q[i].busy, exp_q[i].done);
      end
    end
  endtask

  task automatic test_abort();
    obs_t        got;
    logic [15:0] mask;
    int          hits;
    hits = 0;
    mask = 16'($urandom) | 16'h0008;
    build_model(mask, 4, 1'b0, 1000);
    bus.ch_mask = mask; bus.dwell = 8'd4; bus.mode_cont = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < exp_q.size() && hits < 2; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      got = sample_outputs();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL abort_run cycle %0d: got addr=%0d en=%0b busy=%0b, expected addr=%0d en=%0b busy=%0b",
                 i + 1, got.addr, got.en, got.busy, exp_q[i].addr, exp_q[i].en, exp_q[i].busy);
      end
      if (exp_q[i].addr == 4'd3 && exp_q[i].en) hits++;
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got = sample_outputs();
      checks++;
      if (got !== {4'd3, 3'b000}) begin
        errors++;
        $display("[TB] FAIL abort_stop cycle %0d: got addr=%0d en=%0b busy=%0b done=%0b, expected addr=3 en=0 busy=0 done=0",
                 i, got.addr, got.en, got.busy, got.done);
      end
      @(negedge clk);
    end
    model_addr = 4'd3;
    bus.ch_mask = 16'hFFFF; bus.start = 1'b1; bus.stop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
      got = sample_outputs();
      checks++;
      if (got !== {model_addr, 3'b000}) begin
        errors++;
        $display("[TB] FAIL start_stop_priority cycle %0d: got addr=%0d en=%0b busy=%0b done=%0b, expected addr=%0d en=0 busy=0 done=0",
                 i, got.addr, got.en, got.busy, got.done, model_addr);
      end
    end
  endtask

  task automatic test_reset_mid_dwell();
    obs_t        got;
    logic [15:0] mask;
    mask = 16'($urandom_range(1, 16'hFFFF)) | 16'h0100;
    build_model(mask, 10, 1'b0, 1000);
    bus.ch_mask = mask; bus.dwell = 8'd10; bus.mode_cont = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      got = sample_outputs();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL pre_reset cycle %0d: got addr=%0d en=%0b busy=%0b, expected addr=%0d en=%0b busy=%0b",
                 i + 1, got.addr, got.en, got.busy, exp_q[i].addr, exp_q[i].en, exp_q[i].busy);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = sample_outputs();
    checks++;
    if (got !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_dwell: got addr=%0d en=%0b busy=%0b done=%0b, expected all 0",
               got.addr, got.en, got.busy, got.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_addr = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = sample_outputs();
      checks++;
      if (got !== 7'd0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle cycle %0d: got addr=%0d en=%0b busy=%0b done=%0b, expected all 0",
                 i, got.addr, got.en, got.busy, got.done);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode_cont = 1'b0;
    bus.dwell     = 8'd0;
    bus.ch_mask   = 16'd0;
    test_reset();
    test_single_pass();
    test_random_scans();
    test_empty_mask();
    test_continuous();
    test_abort();
    test_reset_mid_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
